addsub_op_sequencer: RTL and testbench

Upstream control stage for the combinational adder/subtractor (operands A, B, mode S, result ANSWER).
- Accepts one operation through a valid/ready handshake and registers the operands.
- Drives them to the adder/subtractor for one settle cycle, then captures its result.
- Presents the result with status flags through a valid/ready output handshake.
- Turns the purely combinational datapath into a clocked, flow-controlled pipeline element.

---
 rtl/addsub_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_addsub_op_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_op_sequencer.sv
// -----------------------------------------------------------------------------
// addsub_op_sequencer
//
// Wraps a purely combinational adder/subtractor (A, B, S -> ANSWER) in a
// clocked, flow-controlled pipeline element with three states:
//   IDLE : ready for a request. The operands are registered on acceptance.
//   EXEC : the registered operands drive the adder/subtractor for one full
//          settle cycle. ANSWER and the locally computed flags are captured
//          on the next edge.
//   DONE : the result is presented until the consumer takes it.
// With out_ready held high, one operation takes three cycles.
//
// Build option:
//   ADDSUB_SEQ_SATURATE_EN - when defined, a result that overflows is replaced
//   by the signed limit in the direction of the true result. out_ovf still
//   reports the overflow. When the macro is undefined, ANSWER is passed
//   through unchanged and the result wraps around.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_a, in_b, in_sub    operands and mode (0 = A+B, 1 = A-B), sampled on accept
//   as_a, as_b, as_s      registered drive to the adder/subtractor
//   as_answer             combinational result returned by the adder/subtractor
//   out_valid/out_ready   result handshake
//   out_result            captured (optionally saturated) result
//   out_carry             add: carry out; sub: 1 when A >= B (no borrow)
//   out_ovf               two's-complement signed overflow
//   out_zero, out_neg     out_result == 0, out_result MSB
// -----------------------------------------------------------------------------
module addsub_op_sequencer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_s,
    input  logic [WIDTH-1:0] as_answer,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sub_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg, ovf_reg, zero_reg, neg_reg;

    logic             load_ops;
    logic             capture;

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load_ops   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_ops   = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // The operands have been stable on as_* for the whole cycle,
                // so ANSWER has settled by this edge.
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Flags, computed one bit wider than the datapath from the registered
    // operands. They do not depend on as_answer, so a faulty or slow external
    // block cannot corrupt carry or overflow.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   wide_sum;
    logic [WIDTH:0]   wide_diff;
    logic             carry_calc;
    logic             ovf_calc;
    logic [WIDTH-1:0] final_result;

    assign wide_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    assign wide_diff = {1'b0, a_reg} - {1'b0, b_reg};

    always_comb begin
        if (sub_reg) begin
            // A borrow out of the extended subtraction means A < B.
            carry_calc = ~wide_diff[WIDTH];
            ovf_calc   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                         (wide_diff[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
            carry_calc = wide_sum[WIDTH];
            ovf_calc   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (wide_sum[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

`ifdef ADDSUB_SEQ_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // An overflow can only occur when the true result has the same sign as A,
    // so the sign of A selects the limit.
    assign final_result = ovf_calc ? (a_reg[WIDTH-1] ? SAT_MIN : SAT_MAX)
                                   : as_answer;
`else
    assign final_result = as_answer;
`endif

    // -------------------------------------------------------------------------
    // Operand and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sub_reg    <= 1'b0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
        end else begin
            if (load_ops) begin
                a_reg   <= in_a;
                b_reg   <= in_b;
                sub_reg <= in_sub;
            end
            if (capture) begin
                result_reg <= final_result;
                carry_reg  <= carry_calc;
                ovf_reg    <= ovf_calc;
                zero_reg   <= (final_result == '0);
                neg_reg    <= final_result[WIDTH-1];
            end
        end
    end

    // The operand registers drive the adder/subtractor directly. They are
    // stable from the accepting edge until the next accept.
    assign as_a       = a_reg;
    assign as_b       = b_reg;
    assign as_s       = sub_reg;

    assign out_result = result_reg;
    assign out_carry  = carry_reg;
    assign out_ovf    = ovf_reg;
    assign out_zero   = zero_reg;
    assign out_neg    = neg_reg;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
module tb_addsub_op_sequencer;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_sub;
    logic [W-1:0] as_a, as_b;
    logic         as_s;
    logic [W-1:0] as_answer;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry, out_ovf, out_zero, out_neg;

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational adder/subtractor.
    assign as_answer = as_s ? (as_a - as_b) : (as_a + as_b);

    addsub_op_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .as_a      (as_a),
        .as_b      (as_b),
        .as_s      (as_s),
        .as_answer (as_answer),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    function automatic exp_t mk(input logic [W-1:0] res, input logic c, input logic o,
                                input logic z, input logic n);
        exp_t e;
        e.res = res; e.c = c; e.o = o; e.z = z; e.n = n;
        return e;
    endfunction

    // Reference model used for randomised operations.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t         e;
        logic [W:0]   r;
        int           ai, bi, ti;
        ai = (a >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
        bi = (b >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
        ti = s ? ai - bi : ai + bi;
        r  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.c   = s ? (a >= b) : r[W];
        e.o   = (ti > 2**(W-1) - 1) || (ti < -(2**(W-1)));
        e.res = r[W-1:0];
`ifdef ADDSUB_SEQ_SATURATE_EN
        if (e.o) e.res = (ti < 0) ? W'(1 << (W-1)) : W'((1 << (W-1)) - 1);
`endif
        e.z = (e.res == 0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Present an operation, wait for acceptance, push its expectation, and check
    // the EXEC cycle and the one-cycle settle latency. Returns at the negedge
    // where out_valid is expected high. While the DUT is busy, na/nb/ns are
    // presented (with in_valid = keep) to show that they are ignored.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input exp_t e, input logic keep,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns,
                        output logic ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = s;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        sbq.push_back(e);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b00)
            $display("FAIL exec_handshake: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        else passes++;
        checks++;
        if ({as_a, as_b, as_s} !== {a, b, s})
            $display("FAIL exec_drive: as_a=%0d as_b=%0d as_s=%b required %0d %0d %b",
                     as_a, as_b, as_s, a, b, s);
        else passes++;
        in_valid = keep; in_a = na; in_b = nb; in_sub = ns;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1)
            $display("FAIL latency: out_valid=%b one edge after EXEC, required 1", out_valid);
        else passes++;
    endtask

    // Hold out_ready low for 'hold' cycles with stability checks, compare
    // against the scoreboard head, then complete the output handshake.
    task automatic collect(input int hold);
        exp_t         e;
        logic [W-1:0] r0;
        logic [3:0]   f0;
        checks++;
        if (sbq.size() == 0) begin
            $display("FAIL scoreboard_empty: got result %0d, required no result", out_result);
            return;
        end
        passes++;
        e = sbq.pop_front();
        out_ready = 1'b0;
        r0 = out_result;
        f0 = {out_carry, out_ovf, out_zero, out_neg};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_result, out_carry, out_ovf, out_zero, out_neg}
                !== {1'b1, 1'b0, r0, f0})
                $display("FAIL hold_stable: cycle %0d valid=%b in_ready=%b result=%0d flags=%b required 1 0 %0d %b",
                         i, out_valid, in_ready, out_result,
                         {out_carry, out_ovf, out_zero, out_neg}, r0, f0);
            else passes++;
        end
        checks++;
        if (out_result !== e.res) $display("FAIL result: got %b required %b", out_result, e.res);
        else passes++;
        checks++;
        if (out_carry !== e.c) $display("FAIL carry: got %b required %b", out_carry, e.c);
        else passes++;
        checks++;
        if (out_ovf !== e.o) $display("FAIL ovf: got %b required %b", out_ovf, e.o);
        else passes++;
        checks++;
        if (out_zero !== e.z) $display("FAIL zero: got %b required %b", out_zero, e.z);
        else passes++;
        checks++;
        if (out_neg !== e.n) $display("FAIL neg: got %b required %b", out_neg, e.n);
        else passes++;
        $display("txn: result=%b c=%b o=%b z=%b n=%b (expected %b %b %b %b %b)",
                 out_result, out_carry, out_ovf, out_zero, out_neg, e.res, e.c, e.o, e.z, e.n);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL after_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_result, out_carry, out_ovf, out_zero, out_neg, as_a, as_b, as_s}
            !== {1'b0, 1'b1, {W{1'b0}}, 4'b0000, {W{1'b0}}, {W{1'b0}}, 1'b0})
            $display("FAIL reset_state: valid=%b ready=%b result=%0d flags=%b as=%0d/%0d/%b required 0 1 0 0000 0/0/0",
                     out_valid, in_ready, out_result, {out_carry, out_ovf, out_zero, out_neg}, as_a, as_b, as_s);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        else passes++;
        $display("txn: reset released");
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        in_valid = 1'b1; in_a = 6'd20; in_b = 6'd5; in_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL mid_exec_state: in_ready=%b required 0", in_ready);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_result} !== {1'b0, 1'b1, {W{1'b0}}})
            $display("FAIL async_reset: out_valid=%b in_ready=%b result=%0d required 0 1 0",
                     out_valid, in_ready, out_result);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready} !== 2'b01)
                $display("FAIL stale_result: cycle %0d out_valid=%b in_ready=%b required 0 1",
                         i, out_valid, in_ready);
            else passes++;
        end
        $display("txn: reset during EXEC, operation discarded");
    endtask

    task automatic test_vectors();
        logic ok;
        send(6'd10, 6'd57, 1'b1, mk(6'b010001, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 6'd3, 6'd60, 1'b0, ok);
        if (ok) collect(0);
`ifdef ADDSUB_SEQ_SATURATE_EN
        send(6'd31, 6'd1, 1'b0, mk(6'b011111, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 6'd0, 6'd0, 1'b1, ok);
        if (ok) collect(0);
        send(6'd32, 6'd1, 1'b1, mk(6'b100000, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 6'd7, 6'd7, 1'b0, ok);
        if (ok) collect(1);
`else
        send(6'd31, 6'd1, 1'b0, mk(6'b100000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0, 6'd0, 6'd0, 1'b1, ok);
        if (ok) collect(0);
        send(6'd32, 6'd1, 1'b1, mk(6'b011111, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 6'd7, 6'd7, 1'b0, ok);
        if (ok) collect(1);
`endif
        send(6'd63, 6'd1, 1'b0, mk(6'b000000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 6'd9, 6'd9, 1'b1, ok);
        if (ok) collect(0);
    endtask

    task automatic test_backpressure();
        logic ok;
        // A new request (45 - 12) stays asserted throughout DONE and must wait for IDLE.
        send(6'd25, 6'd40, 1'b0, model(6'd25, 6'd40, 1'b0), 1'b1, 6'd45, 6'd12, 1'b1, ok);
        if (!ok) return;
        collect(5);
        // collect returned in IDLE with in_valid still high: the pending
        // request is accepted on the next edge.
        sbq.push_back(model(6'd45, 6'd12, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({in_ready, as_a, as_b, as_s} !== {1'b0, 6'd45, 6'd12, 1'b1})
            $display("FAIL pending_accept: in_ready=%b as=%0d/%0d/%b required 0 45/12/1",
                     in_ready, as_a, as_b, as_s);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL pending_latency: out_valid=%b required 1", out_valid);
        else passes++;
        collect(0);
    endtask

    task automatic test_back_to_back();
        logic         ok;
        logic [W-1:0] a, b;
        logic         s;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom_range(0, 63));
            b = W'($urandom_range(0, 63));
            s = 1'($urandom_range(0, 1));
            send(a, b, s, model(a, b, s), 1'b0, W'($urandom), W'($urandom), 1'($urandom), ok);
            if (ok) collect(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0 || out_valid !== 1'b0)
            $display("FAIL drain: %0d results outstanding, out_valid=%b required 0 0", sbq.size(), out_valid);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
